bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 22 ++
 rtl/bus_arbiter.sv | 103 ++++++++++
 tb/tb_bus_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: master count, owner encoding, active-low levels
// and hold-counter sizing used by the arbiter and its masters.
package bus_arbiter_pkg;

  localparam int unsigned NUM_MASTERS = 4;
  localparam int unsigned OWNER_W     = 2;
  localparam int unsigned HOLD_W      = 8;

  typedef logic [OWNER_W-1:0] owner_t;
  typedef logic [HOLD_W-1:0]  hold_t;

  localparam owner_t BUS_OWNER_MASTER_0 = 2'd0;  // instruction fetch
  localparam owner_t BUS_OWNER_MASTER_1 = 2'd1;
  localparam owner_t BUS_OWNER_MASTER_2 = 2'd2;
  localparam owner_t BUS_OWNER_MASTER_3 = 2'd3;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam hold_t HOLD_MAX = '1;

endpackage

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with parking, no preemption and a
// registered contention timeout flag.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter logic [HOLD_W-1:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m0_req_,
  input  logic               m1_req_,
  input  logic               m2_req_,
  input  logic               m3_req_,
  output logic               m0_grnt_,
  output logic               m1_grnt_,
  output logic               m2_grnt_,
  output logic               m3_grnt_,
  output logic [OWNER_W-1:0] bus_owner,
  output logic               bus_timeout
);

  localparam hold_t TIMEOUT_LIMIT = (TIMEOUT_CYCLES == '0) ? hold_t'(1) : TIMEOUT_CYCLES;

  owner_t                 owner_q, owner_d;
  hold_t                  hold_q, hold_d;
  logic                   timeout_q, timeout_d;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] grnt_n;
  logic                   owner_req;
  logic                   contended;

  assign req       = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign owner_req = req[owner_q];
  assign contended = |(req & ~(NUM_MASTERS'(1) << owner_q));

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q   <= BUS_OWNER_MASTER_0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-owner selection: the owner keeps the bus while requesting; on release
  // the search starts at owner+1, so the releasing master is tried last.
  // NOTE: every always_comb output is defaulted first so no path infers a latch.
  always_comb begin
    owner_d = owner_q;
    if (!owner_req) begin
      case (owner_q)
        BUS_OWNER_MASTER_0:
          if      (req[1]) owner_d = BUS_OWNER_MASTER_1;
          else if (req[2]) owner_d = BUS_OWNER_MASTER_2;
          else if (req[3]) owner_d = BUS_OWNER_MASTER_3;
        BUS_OWNER_MASTER_1:
          if      (req[2]) owner_d = BUS_OWNER_MASTER_2;
          else if (req[3]) owner_d = BUS_OWNER_MASTER_3;
          else if (req[0]) owner_d = BUS_OWNER_MASTER_0;
        BUS_OWNER_MASTER_2:
          if      (req[3]) owner_d = BUS_OWNER_MASTER_3;
          else if (req[0]) owner_d = BUS_OWNER_MASTER_0;
          else if (req[1]) owner_d = BUS_OWNER_MASTER_1;
        default:
          if      (req[0]) owner_d = BUS_OWNER_MASTER_0;
          else if (req[1]) owner_d = BUS_OWNER_MASTER_1;
          else if (req[2]) owner_d = BUS_OWNER_MASTER_2;
      endcase
    end
  end

  // Hold counter and timeout; the flag is computed from the next count so it
  // falls on the same edge the counter clears.
  always_comb begin
    hold_d = hold_q;
    if (!owner_req || owner_d != owner_q) begin
      hold_d = '0;
    end else if (contended && hold_q != HOLD_MAX) begin
      hold_d = hold_q + hold_t'(1);
    end
    timeout_d = (hold_d >= TIMEOUT_LIMIT);
  end

  // Outputs decoded from registers only
  always_comb begin
    grnt_n          = {NUM_MASTERS{DISABLE_}};
    grnt_n[owner_q] = ENABLE_;
  end

  assign m0_grnt_    = grnt_n[0];
  assign m1_grnt_    = grnt_n[1];
  assign m2_grnt_    = grnt_n[2];
  assign m3_grnt_    = grnt_n[3];
  assign bus_owner   = owner_q;
  assign bus_timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, parking, handoff, fairness, wrap,
// no-preemption, timeout (limit 4) and the zero-limit case.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req_, m1_req_, m2_req_, m3_req_;
  logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [1:0] bus_owner;
  logic       bus_timeout;

  logic       z0_grnt_, z1_grnt_, z2_grnt_, z3_grnt_;
  logic [1:0] z_owner;
  logic       z_timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT_CYCLES(8'd4)) u_dut (
    .clk(clk), .reset(reset),
    .m0_req_(m0_req_), .m1_req_(m1_req_), .m2_req_(m2_req_), .m3_req_(m3_req_),
    .m0_grnt_(m0_grnt_), .m1_grnt_(m1_grnt_), .m2_grnt_(m2_grnt_), .m3_grnt_(m3_grnt_),
    .bus_owner(bus_owner), .bus_timeout(bus_timeout)
  );

  bus_arbiter #(.TIMEOUT_CYCLES(8'd0)) u_dut_zero (
    .clk(clk), .reset(reset),
    .m0_req_(m0_req_), .m1_req_(m1_req_), .m2_req_(m2_req_), .m3_req_(m3_req_),
    .m0_grnt_(z0_grnt_), .m1_grnt_(z1_grnt_), .m2_grnt_(z2_grnt_), .m3_grnt_(z3_grnt_),
    .bus_owner(z_owner), .bus_timeout(z_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive requests as a vector {m3,m2,m1,m0}, active-low
  task automatic set_req(input logic [3:0] r_n);
    {m3_req_, m2_req_, m1_req_, m0_req_} = r_n;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] grants();
    return {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};
  endfunction

  task automatic check_owner(input string tag, input logic [1:0] exp_owner, input logic exp_to);
    logic [3:0] exp_g;
    exp_g = 4'b1111;
    exp_g[exp_owner] = 1'b0;
    check({tag, "_grnt"}, grants(), exp_g);
    check({tag, "_owner"}, bus_owner, exp_owner);
    check({tag, "_timeout"}, bus_timeout, exp_to);
  endtask

  initial begin
    // Reset with no requests
    reset = 1'b1;
    set_req(4'b1111);
    step(2);
    check_owner("reset", 2'd0, 1'b0);

    // Parked owner: m0 requests from reset release, no gap
    set_req(4'b1110);
    #2 reset = 1'b0;
    step(1);
    check_owner("park1", 2'd0, 1'b0);
    step(3);
    check_owner("park4", 2'd0, 1'b0);

    // Handoff: grant must not move combinationally on a request change
    set_req(4'b1011);
    #1;
    check_owner("handoff_pre", 2'd0, 1'b0);
    step(1);
    check_owner("handoff", 2'd2, 1'b0);

    // No requests: owner stays parked
    set_req(4'b1111);
    step(3);
    check_owner("idle_park", 2'd2, 1'b0);

    // Reset mid-tenure returns bus to master 0 despite pending requests
    set_req(4'b0011);
    step(1);
    check_owner("pre_reset", 2'd2, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_owner("async_reset", 2'd0, 1'b0);

    // Fairness: all requesting, 3-cycle tenures then a 1-cycle release
    set_req(4'b0000);
    step(1);
    reset = 1'b0;
    for (int m = 0; m < 4; m++) begin
      step(3);
      check_owner($sformatf("fair_hold%0d", m), 2'(m), 1'b0);
      set_req(4'b0000 | (4'b0001 << m));
      step(1);
      check_owner($sformatf("fair_next%0d", m), 2'((m + 1) % 4), 1'b0);
      set_req(4'b0000);
    end

    // Move ownership to master 3, then contend with m0 and m1
    set_req(4'b0111);
    step(1);
    check_owner("to_m3", 2'd3, 1'b0);
    set_req(4'b0100);
    step(1);
    check("zero_limit_to", z_timeout, 1'b1);
    step(2);
    check_owner("wrap_hold3", 2'd3, 1'b0);
    step(1);
    check_owner("wrap_hold4", 2'd3, 1'b1);
    step(3);
    check_owner("no_preempt", 2'd3, 1'b1);
    set_req(4'b1100);
    step(1);
    check_owner("wrap_to_m0", 2'd0, 1'b0);
    check("zero_limit_clr", z_timeout, 1'b0);

    // Timeout: owner 1 holds while m2 requests
    set_req(4'b1101);
    step(1);
    check_owner("to_m1", 2'd1, 1'b0);
    set_req(4'b1001);
    step(3);
    check_owner("to_cnt3", 2'd1, 1'b0);
    step(1);
    check_owner("to_cnt4", 2'd1, 1'b1);
    step(5);
    check_owner("to_stay", 2'd1, 1'b1);
    set_req(4'b1011);
    step(1);
    check_owner("to_release", 2'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
